modulo_transferidor_rolhas: RTL and testbench
=============================================

Name: modulo_transferidor_rolhas

Overview:
Reader side of the secondary cork buffer. On request, it drains one batch of corks from the secondary buffer into the principal (sealing-station) buffer, one cork per clock. It owns the principal-buffer count and decrements it for every cork consumed by the sealer. It flags an empty principal buffer (ro) and a low level to the filling/sealing FSM and the operator-load logic.

Parameters:
BATCH, 20, corks moved per transfer
SEC_W, 7, secondary count width
PRI_W, 5, principal count width (capacity 2^PRI_W-1 = 31)
MIN_LVL, 5, pri_count below this asserts low
AUTO, 0, 1 = low level in IDLE acts as an internal request

Ports:
clk  in  1  system clock (divided clock domain)
rst  in  1  synchronous reset, active-high
enable  in  1  start_stop; 0 aborts any transfer
req  in  1  transfer request, single-cycle pulse
sec_count  in  SEC_W  current secondary-buffer level (external counter)
seal  in  1  one cork consumed by sealer, single-cycle pulse
sec_dec  out  1  one-cycle strobe; external secondary counter decrements by 1
pri_count  out  PRI_W  principal-buffer level
busy  out  1  high in CHECK and XFER
done  out  1  one-cycle pulse when a batch completes
nak  out  1  one-cycle pulse when a request is rejected
abort  out  1  one-cycle pulse when a transfer is cut by enable=0
ro  out  1  pri_count==0
low  out  1  pri_count<MIN_LVL
state  out  2  FSM state code (IDLE=00, CHECK=01, XFER=10, DONE=11)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pri_count=0, internal remaining=0.
  - sec_dec, done, nak, abort = 0.
  - ro=1, low=1, busy=0.
  - rst overrides every other input, including mid-XFER.
- ro, low, busy are combinational from registers. All strobes are registered, one cycle wide.
- IDLE:
  - enable=1 and (req=1, or AUTO=1 and low=1) -> CHECK next cycle.
  - req while enable=0 is ignored silently (no nak).
- CHECK, one cycle:
  - accept when sec_count>=BATCH and pri_count<=31-BATCH, evaluated on this cycle's values.
  - accept -> remaining=BATCH, go to XFER.
  - reject -> nak=1 next cycle, go to IDLE.
- XFER, per cycle:
  - seal=0: sec_dec=1, pri_count+1, remaining-1.
  - remaining reaching 0 -> DONE.
  - first sec_dec is asserted the cycle after CHECK. A full batch with no seal takes BATCH cycles.
- Seal priority:
  - seal=1 during XFER pauses the transfer that cycle: no sec_dec, remaining held.
  - pri_count-1 applies when pri_count>0.
  - transfer and consume are never applied in the same cycle.
- Seal in any other state: pri_count-1 when pri_count>0.
- Seal when pri_count==0: ignored. No wrap; count saturates at 0.
- Overflow: the CHECK guard ensures pri_count never exceeds 31; no wrap-around is possible.
- enable=0 in CHECK or XFER:
  - -> IDLE next cycle, abort=1, remaining=0.
  - pri_count keeps the corks already moved. No sec_dec that cycle.
- DONE: done=1 for one cycle, then IDLE. A req arriving in DONE is dropped.
- req arriving while busy is dropped; no queueing.
- Total latency from req to done: 1 (CHECK) + BATCH + number of seal cycles during XFER + 1.

Test Plan:
- Reset: assert rst with any inputs -> pri_count=0, ro=1, low=1, state=00, all strobes 0.
- Nominal transfer: sec_count=40, pri_count=0, pulse req.
  - sec_dec high for exactly 20 consecutive cycles starting 2 cycles after req.
  - pri_count=20; done pulses once; low=0, ro=0.
- Rejections:
  - sec_count=19, req -> nak one cycle, no sec_dec, pri_count unchanged.
  - pri_count=12, sec_count=50, req -> nak (12>11).
- Seal during transfer: seal pulses at the 5th and 6th XFER cycles -> 2 paused cycles.
  - done arrives 2 cycles later than nominal; final pri_count=18; total sec_dec count 20.
- Abort: deassert enable after 7 sec_dec strobes -> abort=1, state IDLE, pri_count=7.
  - a subsequent seal -> pri_count=6.
- Underflow and auto request:
  - pri_count=0 with seal pulses -> pri_count stays 0, ro=1.
  - AUTO=1, pri_count=4, sec_count=30, enable=1, no req -> CHECK entered, batch transfers, pri_count=24.

Source files
------------

// File: rtl/modulo_transferidor_rolhas.sv
// Secondary cork buffer reader: moves one batch of corks into the principal
// buffer, one per clock, and tracks the principal level consumed by the sealer.
module modulo_transferidor_rolhas #(
   parameter int BATCH   = 20,
   parameter int SEC_W   = 7,
   parameter int PRI_W   = 5,
   parameter int MIN_LVL = 5,
   parameter int AUTO    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             req,
   input  logic [SEC_W-1:0] sec_count,
   input  logic             seal,
   output logic             sec_dec,
   output logic [PRI_W-1:0] pri_count,
   output logic             busy,
   output logic             done,
   output logic             nak,
   output logic             abort,
   output logic             ro,
   output logic             low,
   output logic [1:0]       state
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_CHECK = 2'b01;
   localparam logic [1:0] S_XFER  = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   localparam int REM_W = $clog2(BATCH + 1);
   localparam int PRI_MAX = (1 << PRI_W) - 1;

   localparam logic [SEC_W-1:0] BATCH_SEC = SEC_W'(BATCH);
   localparam logic [PRI_W-1:0] PRI_ROOM  = PRI_W'(PRI_MAX - BATCH);
   localparam logic [PRI_W-1:0] LOW_LVL   = PRI_W'(MIN_LVL);
   localparam logic [REM_W-1:0] BATCH_REM = REM_W'(BATCH);
   localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);

   logic [REM_W-1:0] remaining;
   logic             accept;
   logic             xfer_go;
   logic             start;

   assign ro   = (pri_count == '0);
   assign low  = (pri_count < LOW_LVL);
   assign busy = (state == S_CHECK) || (state == S_XFER);

   // The room check bounds pri_count at PRI_MAX, so the +1 below never wraps.
   assign accept  = (sec_count >= BATCH_SEC) && (pri_count <= PRI_ROOM);
   assign xfer_go = (state == S_XFER) && enable && !seal;
   assign start   = enable && (req || ((AUTO != 0) && low));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pri_count <= '0;
         remaining <= '0;
         sec_dec   <= 1'b0;
         done      <= 1'b0;
         nak       <= 1'b0;
         abort     <= 1'b0;
      end else begin
         sec_dec <= 1'b0;
         done    <= 1'b0;
         nak     <= 1'b0;
         abort   <= 1'b0;

         // A seal pauses the transfer, so increment and decrement never coincide.
         if (xfer_go)
            pri_count <= pri_count + 1'b1;
         else if (seal && (pri_count != '0))
            pri_count <= pri_count - 1'b1;

         case (state)
            S_IDLE: begin
               if (start)
                  state <= S_CHECK;
            end
            S_CHECK: begin
               if (!enable) begin
                  abort     <= 1'b1;
                  remaining <= '0;
                  state     <= S_IDLE;
               end else if (accept) begin
                  remaining <= BATCH_REM;
                  state     <= S_XFER;
               end else begin
                  nak   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_XFER: begin
               if (!enable) begin
                  abort     <= 1'b1;
                  remaining <= '0;
                  state     <= S_IDLE;
               end else if (!seal) begin
                  sec_dec   <= 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == REM_ONE)
                     state <= S_DONE;
               end
            end
            default: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modulo_transferidor_rolhas.sv
// Directed bench for modulo_transferidor_rolhas: default instance plus an AUTO=1 instance.
module tb_modulo_transferidor_rolhas;

   logic       clk = 1'b0;
   logic       rst, enable, req, seal;
   logic [6:0] sec_count;
   logic       sec_dec, busy, done, nak, abort, ro, low;
   logic [4:0] pri_count;
   logic [1:0] state;

   logic       enable_a, req_a, seal_a;
   logic [6:0] sec_a;
   logic       sec_dec_a, busy_a, done_a, nak_a, abort_a, ro_a, low_a;
   logic [4:0] pri_a;
   logic [1:0] state_a;

   int total = 0;
   int bad   = 0;

   modulo_transferidor_rolhas dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req), .sec_count(sec_count),
      .seal(seal), .sec_dec(sec_dec), .pri_count(pri_count), .busy(busy),
      .done(done), .nak(nak), .abort(abort), .ro(ro), .low(low), .state(state)
   );

   modulo_transferidor_rolhas #(.AUTO(1)) dut_auto (
      .clk(clk), .rst(rst), .enable(enable_a), .req(req_a), .sec_count(sec_a),
      .seal(seal_a), .sec_dec(sec_dec_a), .pri_count(pri_a), .busy(busy_a),
      .done(done_a), .nak(nak_a), .abort(abort_a), .ro(ro_a), .low(low_a), .state(state_a)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; seal = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // t counts edges after the edge that sampled req; seal is held for edges s1 and s2.
   task automatic observe(input int nmax, input int s1, input int s2,
                          output int first_sd, output int last_sd, output int n_sd,
                          output int done_t, output int n_done);
      first_sd = -1; last_sd = -1; n_sd = 0; done_t = -1; n_done = 0;
      for (int t = 1; t <= nmax; t++) begin
         seal = (t == s1) || (t == s2);
         tick();
         seal = 1'b0;
         if (sec_dec) begin
            if (first_sd < 0) first_sd = t;
            last_sd = t;
            n_sd++;
         end
         if (done) begin
            if (done_t < 0) done_t = t;
            n_done++;
         end
      end
   endtask

   task automatic pulse_req();
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   int f, l, n, dt, nd, cnt;

   initial begin
      enable = 1'b1; req = 1'b1; seal = 1'b1; sec_count = 7'd99;
      enable_a = 1'b0; req_a = 1'b0; seal_a = 1'b0; sec_a = 7'd30;

      // reset with every input active
      rst = 1'b1;
      tick(); tick();
      check("rst_state", int'(state), 0);
      check("rst_pri", int'(pri_count), 0);
      check("rst_ro", int'(ro), 1);
      check("rst_low", int'(low), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_strobes", int'({sec_dec, done, nak, abort}), 0);
      rst = 1'b0; req = 1'b0; seal = 1'b0;

      // nominal transfer
      sec_count = 7'd40;
      pulse_req();
      check("nom_check_state", int'(state), 1);
      check("nom_busy", int'(busy), 1);
      observe(30, -1, -1, f, l, n, dt, nd);
      check("nom_first_sd", f, 2);
      check("nom_last_sd", l, 21);
      check("nom_n_sd", n, 20);
      check("nom_done_t", dt, 22);
      check("nom_n_done", nd, 1);
      check("nom_pri", int'(pri_count), 20);
      check("nom_ro", int'(ro), 0);
      check("nom_low", int'(low), 0);

      // reset overrides an ongoing transfer
      do_reset();
      pulse_req();
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_state", int'(state), 0);
      check("rst_mid_pri", int'(pri_count), 0);

      // seal during 5th and 6th XFER cycles
      pulse_req();
      observe(30, 6, 7, f, l, n, dt, nd);
      check("seal_first_sd", f, 2);
      check("seal_last_sd", l, 23);
      check("seal_n_sd", n, 20);
      check("seal_done_t", dt, 24);
      check("seal_pri", int'(pri_count), 18);

      // abort after 7 strobes
      do_reset();
      pulse_req();
      cnt = 0;
      for (int t = 0; t < 30 && cnt < 7; t++) begin
         tick();
         if (sec_dec) cnt++;
      end
      check("abort_sd_seen", cnt, 7);
      enable = 1'b0;
      tick();
      check("abort_pulse", int'(abort), 1);
      check("abort_state", int'(state), 0);
      check("abort_no_sd", int'(sec_dec), 0);
      check("abort_pri", int'(pri_count), 7);
      enable = 1'b1; seal = 1'b1;
      tick();
      seal = 1'b0;
      check("abort_one_cycle", int'(abort), 0);
      check("abort_seal_pri", int'(pri_count), 6);

      // rejection: not enough corks in secondary
      do_reset();
      sec_count = 7'd19;
      pulse_req();
      check("rej1_check", int'(state), 1);
      tick();
      check("rej1_nak", int'(nak), 1);
      check("rej1_state", int'(state), 0);
      check("rej1_sd", int'(sec_dec), 0);
      check("rej1_pri", int'(pri_count), 0);
      tick();
      check("rej1_nak_clr", int'(nak), 0);

      // rejection: principal too full (12 > 11)
      sec_count = 7'd40;
      pulse_req();
      observe(30, -1, -1, f, l, n, dt, nd);
      seal = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      seal = 1'b0;
      check("rej2_pre_pri", int'(pri_count), 12);
      sec_count = 7'd50;
      pulse_req();
      tick();
      check("rej2_nak", int'(nak), 1);
      check("rej2_pri", int'(pri_count), 12);

      // boundary accept: pri=11, sec=20 fills to 31
      seal = 1'b1; tick(); seal = 1'b0;
      sec_count = 7'd20;
      pulse_req();
      tick();
      check("bnd_xfer", int'(state), 2);
      check("bnd_no_nak", int'(nak), 0);
      for (int i = 0; i < 25; i++) tick();
      check("bnd_pri", int'(pri_count), 31);

      // req while disabled is ignored
      enable = 1'b0;
      pulse_req();
      check("dis_state", int'(state), 0);
      check("dis_nak", int'(nak), 0);
      enable = 1'b1;

      // underflow saturates at zero
      do_reset();
      seal = 1'b1;
      tick(); tick(); tick();
      seal = 1'b0;
      check("uf_pri", int'(pri_count), 0);
      check("uf_ro", int'(ro), 1);

      // AUTO instance: low level self-requests
      do_reset();
      enable_a = 1'b1;
      dt = -1;
      for (int t = 1; t <= 40 && dt < 0; t++) begin
         tick();
         if (done_a) dt = t;
      end
      check("auto1_done_t", dt, 23);
      check("auto1_pri", int'(pri_a), 20);
      seal_a = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      seal_a = 1'b0;
      check("auto_pri4", int'(pri_a), 4);
      check("auto_idle", int'(state_a), 0);
      tick();
      check("auto_check", int'(state_a), 1);
      dt = -1;
      for (int t = 1; t <= 40 && dt < 0; t++) begin
         tick();
         if (done_a) dt = t;
      end
      check("auto2_done_t", dt, 22);
      check("auto2_pri", int'(pri_a), 24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
